// File: rtl/sdr_ctrl_pkg.sv
// rtl/sdr_ctrl_pkg.sv - shared state encoding for the sweep controller
// Contents:
//   sweep_state_t : IDLE / RUN state encoding
//   effective_dwell : maps a requested dwell of 0 onto 1
package sdr_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sweep_state_t;

  // A dwell of zero would never complete a step, so it behaves as one tick.
  function automatic logic [31:0] effective_dwell(input logic [31:0] dwell);
    return (dwell == 32'd0) ? 32'd1 : dwell;
  endfunction

endpackage

// File: rtl/axis_sweep_controller_if.sv
// rtl/axis_sweep_controller_if.sv - signal bundle around the sweep controller
// Members:
//   cfg_start_inc, cfg_step_inc, cfg_steps, cfg_dwell, cfg_repeat : sweep config
//   start, abort, sample_tick : control strobes
//   phase_inc, step_index, busy, done : status / generator drive
// Modports:
//   master : drives config and strobes, observes status
//   slave  : the controller side
interface axis_sweep_controller_if #(
  parameter int PHASE_WIDTH = 30,
  parameter int CNTR_WIDTH  = 32
);

  logic [PHASE_WIDTH-1:0] cfg_start_inc;
  logic [PHASE_WIDTH-1:0] cfg_step_inc;
  logic [CNTR_WIDTH-1:0]  cfg_steps;
  logic [CNTR_WIDTH-1:0]  cfg_dwell;
  logic                   cfg_repeat;
  logic                   start;
  logic                   abort;
  logic                   sample_tick;
  logic [PHASE_WIDTH-1:0] phase_inc;
  logic [CNTR_WIDTH-1:0]  step_index;
  logic                   busy;
  logic                   done;

  modport master (
    output cfg_start_inc, cfg_step_inc, cfg_steps, cfg_dwell, cfg_repeat,
    output start, abort, sample_tick,
    input  phase_inc, step_index, busy, done
  );

  modport slave (
    input  cfg_start_inc, cfg_step_inc, cfg_steps, cfg_dwell, cfg_repeat,
    input  start, abort, sample_tick,
    output phase_inc, step_index, busy, done
  );

endinterface

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - dwell counter counting accepted sample ticks
// Ports:
//   aclk, aresetn : clock, synchronous active-low reset
//   load          : clear the count to 0
//   tick          : count one accepted sample
//   last          : terminal count value (dwell - 1)
//   terminal      : this tick completes the dwell (count wraps to 0)
module tick_divider #(
  parameter int WIDTH = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             load,
  input  logic             tick,
  input  logic [WIDTH-1:0] last,
  output logic             terminal
);

  logic [WIDTH-1:0] count;

  // Terminal is internal to the controller; it is consumed by registered logic.
  assign terminal = tick && (count == last);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (tick) begin
      if (count == last) begin
        count <= '0;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/axis_sweep_controller.sv
// rtl/axis_sweep_controller.sv - stepped phase-increment sweep sequencer
// Ports:
//   aclk, aresetn        : clock, synchronous active-low reset
//   cfg_start_inc        : phase increment of the first step
//   cfg_step_inc         : signed per-step increment (wraps modulo 2^PHASE_WIDTH)
//   cfg_steps            : steps after the first
//   cfg_dwell            : sample ticks per step (0 treated as 1)
//   cfg_repeat           : restart sweep on completion
//   start, abort         : single-cycle control strobes (abort wins)
//   sample_tick          : one generator sample accepted downstream
//   phase_inc            : registered increment to the phase generator
//   step_index           : registered current step
//   busy                 : high while running
//   done                 : one-cycle pulse at non-repeating completion
module axis_sweep_controller
  import sdr_ctrl_pkg::*;
#(
  parameter int PHASE_WIDTH = 30,
  parameter int CNTR_WIDTH  = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [PHASE_WIDTH-1:0] cfg_start_inc,
  input  logic [PHASE_WIDTH-1:0] cfg_step_inc,
  input  logic [CNTR_WIDTH-1:0]  cfg_steps,
  input  logic [CNTR_WIDTH-1:0]  cfg_dwell,
  input  logic                   cfg_repeat,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   sample_tick,
  output logic [PHASE_WIDTH-1:0] phase_inc,
  output logic [CNTR_WIDTH-1:0]  step_index,
  output logic                   busy,
  output logic                   done
);

  sweep_state_t           state;
  logic [PHASE_WIDTH-1:0] start_inc_q;
  logic [PHASE_WIDTH-1:0] step_inc_q;
  logic [CNTR_WIDTH-1:0]  steps_q;
  logic [CNTR_WIDTH-1:0]  dwell_q;
  logic                   repeat_q;
  logic                   dwell_done;
  logic                   div_load;
  logic                   div_tick;
  logic [CNTR_WIDTH-1:0]  dwell_in;

  // Counter is held cleared outside RUN so every sweep starts at count 0.
  assign div_load = abort || (state == ST_IDLE);
  assign div_tick = sample_tick && (state == ST_RUN);
  assign busy     = (state == ST_RUN);

  always_comb begin
    dwell_in = cfg_dwell;
    if (cfg_dwell == '0) begin
      dwell_in = CNTR_WIDTH'(1);
    end
  end

  tick_divider #(.WIDTH(CNTR_WIDTH)) u_dwell (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     (div_load),
    .tick     (div_tick),
    .last     (dwell_q - CNTR_WIDTH'(1)),
    .terminal (dwell_done)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      phase_inc   <= '0;
      step_index  <= '0;
      done        <= 1'b0;
      start_inc_q <= '0;
      step_inc_q  <= '0;
      steps_q     <= '0;
      dwell_q     <= '0;
      repeat_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state      <= ST_IDLE;
        phase_inc  <= '0;
        step_index <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              start_inc_q <= cfg_start_inc;
              step_inc_q  <= cfg_step_inc;
              steps_q     <= cfg_steps;
              dwell_q     <= dwell_in;
              repeat_q    <= cfg_repeat;
              phase_inc   <= cfg_start_inc;
              step_index  <= '0;
              state       <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (dwell_done) begin
              if (step_index < steps_q) begin
                phase_inc  <= phase_inc + step_inc_q;
                step_index <= step_index + CNTR_WIDTH'(1);
              end else if (repeat_q) begin
                phase_inc  <= start_inc_q;
                step_index <= '0;
              end else begin
                state      <= ST_IDLE;
                phase_inc  <= '0;
                step_index <= '0;
                done       <= 1'b1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
